textram_wb: RTL and testbench
=============================

// Module: textram_wb
// PURPOSE
//  Wishbone classic slave serving the text-mode character RAM and cursor registers.
//  A text driver fetches 32-bit words here as bus master, each word holding two characters
//  {color0[31:24], char0[22:16], color1[15:8], char1[6:0]}; the CPU writes screen text here.
//  Drives cursorpos/cursormode/cursorcolor to the text driver. Single clock domain.
// PARAMETERS
//  AWIDTH   12          text RAM word-address width; DEPTH = 2**AWIDTH 32-bit words
//  REGBIT   16          byte-address bit selecting register space (1) vs text RAM (0)
// PORTS
//  clk_i        in     1       system clock; all logic on rising edge
//  rst_i        in     1       reset, asynchronous, active-high
//  bus          slave  if_wb   cyc, stb, we, sel[3:0], adr[31:0] (byte addr), data in/out [31:0], ack
//  cursorpos    out    32      {row[15:0], col[15:0]} cursor position
//  cursormode   out    4       3 = blinking, 4 = solid, other = off
//  cursorcolor  out    24      RGB888 cursor colour
// BEHAVIOUR
//  Decode: region = adr[REGBIT]; RAM word index = adr[AWIDTH+1:2]; reg index = adr[3:2].
//   Other address bits are ignored (RAM aliases).
//  Registers: 0 cursorpos (RW, 32b); 1 cursormode (RW, bits 3:0; upper bits read 0);
//   2 cursorcolor (RW, bits 23:0; upper bits read 0); 3 ID (RO, 32'h5458_0000 | AWIDTH).
//   Writes to ID are acked and ignored.
//  Byte lanes: sel[n] enables byte n on RAM and register writes; sel is ignored on reads.
//  FSM states: S_IDLE, S_RAMRD, S_ACK.
//   S_IDLE: when cyc & stb are sampled high, the request is captured:
//    - write (RAM or reg): commit at this edge, go to S_ACK;
//    - reg read: latch the register value into dat_o, go to S_ACK;
//    - RAM read: present address to sync RAM (1-cycle read), go to S_RAMRD.
//   S_RAMRD: latch RAM q into dat_o, go to S_ACK. If cyc is low here: go to S_IDLE, no ack.
//   S_ACK: ack=1 for exactly one cycle, then S_IDLE unconditionally.
//  ack is a decode of state == S_ACK (registered, glitch-free). It is never high two cycles running.
//  Latency (request-sampled edge to ack-high cycle): write 1 clk, reg read 1 clk, RAM read 2 clks.
//  Back-to-back: a new request held on the cycle after ack is accepted from S_IDLE. Throughput:
//   1 transfer per 2 clks (writes/reg reads), per 3 clks (RAM reads).
//  dat_o is registered and valid only while ack=1; otherwise it holds its last value. Reset value 0.
//  stb without cyc is ignored. Abort (cyc drop) after a committed write leaves the write done.
//  RAM write and read to the same word in successive requests: the read returns the new data.
//  Reset (async, any state, incl. mid-transfer): state=S_IDLE, ack=0, dat_o=0, cursorpos=0,
//   cursormode=0, cursorcolor=24'hFFFFFF. RAM contents are not reset. An in-flight transfer
//   is dropped without ack.
//  Register outputs update on the edge after the write commits; there is no shadowing.
// TESTING
//  1 RAM write adr=0x0000_0010 dat=0x0F41_0F42 sel=F -> ack 1 clk later; read adr=0x10 -> ack after
//    2 clks, dat=0x0F41_0F42.
//  2 Byte lanes: write 0xAABBCCDD sel=F, then 0x11223344 sel=4'b0101 -> read returns 0xAA22CC44.
//  3 Regs: write adr=0x1_0000 0x0005_0010 -> cursorpos=0x0005_0010 next clk; write cursormode 0xFFFF_FFF3
//    -> reads back 0x3; read adr=0x1_000C -> 0x5458_000C.
//  4 Abort: RAM read, drop cyc in S_RAMRD -> no ack, FSM back in S_IDLE; the next write still acks normally.
//  5 Reset mid-transfer: assert rst_i while in S_RAMRD -> ack=0 and dat_o=0 immediately, cursorcolor=FFFFFF,
//    RAM word from test 1 preserved.
//  6 Back-to-back: 40 consecutive RAM reads (driver row fetch), stb held high -> 40 acks, each
//    1 clk wide, 3 clks apart; no double-ack.

Source files
------------

// File: rtl/textram_wb.sv
// Wishbone classic slave for the text-mode character RAM and cursor registers.
// Ack 1 clk after a write or register read, 2 clks after a RAM read; the bus waits for ack.
module textram_wb #(
  parameter int AWIDTH = 12,
  parameter int REGBIT = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [3:0]          wb_sel_i,
  input  logic [31:0]         wb_adr_i,
  input  logic [31:0]         wb_dat_i,
  output logic [31:0]         wb_dat_o,
  output logic                wb_ack_o,
  output logic [31:0]         cursorpos_o,
  output logic [3:0]          cursormode_o,
  output logic [23:0]         cursorcolor_o
);

  localparam int          DEPTH  = 1 << AWIDTH;
  localparam logic [31:0] ID_VAL = 32'h5458_0000 | 32'(AWIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RAMRD = 2'd1,
    S_ACK   = 2'd2
  } state_e;

  state_e              state_q;
  logic                ack_q;
  logic [31:0]         dat_q;
  logic [31:0]         pos_q;
  logic [3:0]          mode_q;
  logic [23:0]         color_q;

  logic [31:0]         mem [DEPTH];
  logic [31:0]         ram_q;

  logic                req;
  logic                is_reg;
  logic                ram_we;
  logic [AWIDTH-1:0]   ram_idx;
  logic [1:0]          reg_idx;
  logic [31:0]         reg_rd;
  logic                unused_adr;

  assign req     = (state_q == S_IDLE) && wb_cyc_i && wb_stb_i;
  assign is_reg  = wb_adr_i[REGBIT];
  assign ram_idx = wb_adr_i[AWIDTH+1:2];
  assign reg_idx = wb_adr_i[3:2];
  assign ram_we  = req && wb_we_i && !is_reg;

  // Remaining address bits are don't-care; the RAM aliases across them.
  assign unused_adr = ^wb_adr_i;

  always_comb begin
    reg_rd = 32'h0;
    case (reg_idx)
      2'd0:    reg_rd = pos_q;
      2'd1:    reg_rd = {28'h0, mode_q};
      2'd2:    reg_rd = {8'h0, color_q};
      default: reg_rd = ID_VAL;
    endcase
  end

  // Text RAM: byte-lane writes, one-cycle registered read, contents never reset.
  always_ff @(posedge clk_i) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wb_sel_i[b]) mem[ram_idx][8*b +: 8] <= wb_dat_i[8*b +: 8];
      end
    end
    ram_q <= mem[ram_idx];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      dat_q   <= 32'h0;
      pos_q   <= 32'h0;
      mode_q  <= 4'h0;
      color_q <= 24'hFF_FFFF;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req) begin
            if (wb_we_i) begin
              if (is_reg) begin
                case (reg_idx)
                  2'd0: begin
                    for (int b = 0; b < 4; b++) begin
                      if (wb_sel_i[b]) pos_q[8*b +: 8] <= wb_dat_i[8*b +: 8];
                    end
                  end
                  2'd1: begin
                    if (wb_sel_i[0]) mode_q <= wb_dat_i[3:0];
                  end
                  2'd2: begin
                    for (int b = 0; b < 3; b++) begin
                      if (wb_sel_i[b]) color_q[8*b +: 8] <= wb_dat_i[8*b +: 8];
                    end
                  end
                  default: ;
                endcase
              end
              state_q <= S_ACK;
              ack_q   <= 1'b1;
            end else if (is_reg) begin
              dat_q   <= reg_rd;
              state_q <= S_ACK;
              ack_q   <= 1'b1;
            end else begin
              state_q <= S_RAMRD;
            end
          end
        end
        S_RAMRD: begin
          // A master that drops cyc here has abandoned the read; no ack follows.
          if (!wb_cyc_i) begin
            state_q <= S_IDLE;
          end else begin
            dat_q   <= ram_q;
            state_q <= S_ACK;
            ack_q   <= 1'b1;
          end
        end
        S_ACK: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign wb_ack_o      = ack_q;
  assign wb_dat_o      = dat_q;
  assign cursorpos_o   = pos_q;
  assign cursormode_o  = mode_q;
  assign cursorcolor_o = color_q;

endmodule

// File: tb/tb_textram_wb.sv
// Directed bench for textram_wb: RAM/register access, byte lanes, abort, reset and streaming reads.
module tb_textram_wb;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_adr_i, wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic [31:0] cursorpos_o;
  logic [3:0]  cursormode_o;
  logic [23:0] cursorcolor_o;

  int checks = 0;
  int errors = 0;

  textram_wb #(.AWIDTH(12), .REGBIT(16)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .wb_cyc_i      (wb_cyc_i),
    .wb_stb_i      (wb_stb_i),
    .wb_we_i       (wb_we_i),
    .wb_sel_i      (wb_sel_i),
    .wb_adr_i      (wb_adr_i),
    .wb_dat_i      (wb_dat_i),
    .wb_dat_o      (wb_dat_o),
    .wb_ack_o      (wb_ack_o),
    .cursorpos_o   (cursorpos_o),
    .cursormode_o  (cursormode_o),
    .cursorcolor_o (cursorcolor_o)
  );

  always #5 clk_i = ~clk_i;

  // One classic cycle; lat counts edges from request to ack-high (0 if none within budget).
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rdat, output int lat);
    int n;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr;  wb_dat_i = dat;  wb_sel_i = sel;
    n = 0;
    lat = 0;
    while (lat == 0 && n < 20) begin
      @(posedge clk_i); #1;
      n++;
      if (wb_ack_o) lat = n;
    end
    rdat = wb_dat_o;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if (wb_ack_o !== 1'b0 || wb_dat_o !== 32'h0) begin
      errors++; $display("FAIL reset_bus: ack=%b dat=%h, want ack=0 dat=0", wb_ack_o, wb_dat_o);
    end
    checks++;
    if (cursorpos_o !== 32'h0 || cursormode_o !== 4'h0 || cursorcolor_o !== 24'hFFFFFF) begin
      errors++; $display("FAIL reset_regs: pos=%h mode=%h color=%h, want 0/0/ffffff",
                         cursorpos_o, cursormode_o, cursorcolor_o);
    end
  endtask

  task automatic test_ram_rw;
    logic [31:0] r; int lat;
    wb_xfer(1'b1, 32'h0000_0010, 32'h0F41_0F42, 4'hF, r, lat);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL ram_wr_lat: got %0d want 1", lat); end
    @(posedge clk_i); #1;
    wb_xfer(1'b0, 32'h0000_0010, 32'h0, 4'h0, r, lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL ram_rd_lat: got %0d want 2", lat); end
    checks++;
    if (r !== 32'h0F41_0F42) begin errors++; $display("FAIL ram_rd_dat: got %h want 0f410f42", r); end
    @(posedge clk_i); #1;
    checks++;
    if (wb_ack_o !== 1'b0) begin errors++; $display("FAIL ack_width: ack=%b want 0", wb_ack_o); end
    // Bit 14 lies above the word index, so this aliases word 4.
    wb_xfer(1'b0, 32'h0000_4010, 32'h0, 4'h0, r, lat);
    checks++;
    if (r !== 32'h0F41_0F42) begin errors++; $display("FAIL ram_alias: got %h want 0f410f42", r); end
    @(posedge clk_i); #1;
  endtask

  task automatic test_byte_lanes;
    logic [31:0] r; int lat;
    wb_xfer(1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'hF, r, lat);
    @(posedge clk_i); #1;
    wb_xfer(1'b1, 32'h0000_0020, 32'h1122_3344, 4'b0101, r, lat);
    @(posedge clk_i); #1;
    wb_xfer(1'b0, 32'h0000_0020, 32'h0, 4'h0, r, lat);
    checks++;
    if (r !== 32'hAA22_CC44) begin errors++; $display("FAIL byte_lanes: got %h want aa22cc44", r); end
    @(posedge clk_i); #1;
  endtask

  task automatic test_regs;
    logic [31:0] r; int lat;
    wb_xfer(1'b1, 32'h0001_0000, 32'h0005_0010, 4'hF, r, lat);
    checks++;
    if (lat !== 1 || cursorpos_o !== 32'h0005_0010) begin
      errors++; $display("FAIL reg_pos: lat=%0d pos=%h want 1/00050010", lat, cursorpos_o);
    end
    @(posedge clk_i); #1;
    wb_xfer(1'b1, 32'h0001_0004, 32'hFFFF_FFF3, 4'hF, r, lat);
    @(posedge clk_i); #1;
    wb_xfer(1'b0, 32'h0001_0004, 32'h0, 4'h0, r, lat);
    checks++;
    if (r !== 32'h0000_0003 || lat !== 1) begin
      errors++; $display("FAIL reg_mode_rd: got %h lat=%0d want 00000003 lat=1", r, lat);
    end
    checks++;
    if (cursormode_o !== 4'h3) begin errors++; $display("FAIL reg_mode_out: got %h want 3", cursormode_o); end
    @(posedge clk_i); #1;
    wb_xfer(1'b1, 32'h0001_0008, 32'h1234_5678, 4'b0011, r, lat);
    @(posedge clk_i); #1;
    wb_xfer(1'b0, 32'h0001_0008, 32'h0, 4'h0, r, lat);
    checks++;
    if (r !== 32'h00FF_5678 || cursorcolor_o !== 24'hFF5678) begin
      errors++; $display("FAIL reg_color: rd=%h out=%h want 00ff5678/ff5678", r, cursorcolor_o);
    end
    @(posedge clk_i); #1;
    wb_xfer(1'b1, 32'h0001_000C, 32'hDEAD_BEEF, 4'hF, r, lat);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL id_wr_ack: lat=%0d want 1", lat); end
    @(posedge clk_i); #1;
    wb_xfer(1'b0, 32'h0001_000C, 32'h0, 4'h0, r, lat);
    checks++;
    if (r !== 32'h5458_000C) begin errors++; $display("FAIL reg_id: got %h want 5458000c", r); end
    @(posedge clk_i); #1;
  endtask

  task automatic test_abort;
    logic [31:0] r; int lat;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h0000_0010;
    @(posedge clk_i); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(posedge clk_i); #1;
    checks++;
    if (wb_ack_o !== 1'b0) begin errors++; $display("FAIL abort_ack1: ack=%b want 0", wb_ack_o); end
    @(posedge clk_i); #1;
    checks++;
    if (wb_ack_o !== 1'b0) begin errors++; $display("FAIL abort_ack2: ack=%b want 0", wb_ack_o); end
    wb_xfer(1'b1, 32'h0000_0030, 32'h5555_AAAA, 4'hF, r, lat);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL abort_next_wr: lat=%0d want 1", lat); end
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset_mid;
    logic [31:0] r; int lat;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h0000_0010;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    #1;
    checks++;
    if (wb_ack_o !== 1'b0 || wb_dat_o !== 32'h0 || cursorcolor_o !== 24'hFFFFFF || cursorpos_o !== 32'h0) begin
      errors++; $display("FAIL reset_mid: ack=%b dat=%h color=%h pos=%h want 0/0/ffffff/0",
                         wb_ack_o, wb_dat_o, cursorcolor_o, cursorpos_o);
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(posedge clk_i); #1;
    checks++;
    if (wb_ack_o !== 1'b0) begin errors++; $display("FAIL reset_mid_noack: ack=%b want 0", wb_ack_o); end
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    wb_xfer(1'b0, 32'h0000_0010, 32'h0, 4'h0, r, lat);
    checks++;
    if (r !== 32'h0F41_0F42 || lat !== 2) begin
      errors++; $display("FAIL ram_preserved: got %h lat=%0d want 0f410f42 lat=2", r, lat);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_back_to_back;
    logic [31:0] r; int lat;
    int acks, cyc_n, last_ack, bad_gap, bad_dat;
    logic prev_ack;
    for (int i = 0; i < 40; i++) begin
      wb_xfer(1'b1, 32'h0000_0400 + 32'(4*i), 32'hC0DE_0000 + 32'(i), 4'hF, r, lat);
      @(posedge clk_i); #1;
    end
    acks = 0; cyc_n = 0; last_ack = 0; bad_gap = 0; bad_dat = 0; prev_ack = 1'b0;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h0000_0400;
    while (acks < 40 && cyc_n < 400) begin
      @(posedge clk_i); #1;
      cyc_n++;
      if (wb_ack_o && prev_ack) bad_gap++;
      if (wb_ack_o) begin
        if (acks > 0 && cyc_n - last_ack != 3) bad_gap++;
        if (wb_dat_o !== 32'hC0DE_0000 + 32'(acks)) bad_dat++;
        last_ack = cyc_n;
        acks++;
        wb_adr_i = 32'h0000_0400 + 32'(4*acks);
      end
      prev_ack = wb_ack_o;
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    checks++;
    if (acks !== 40) begin errors++; $display("FAIL b2b_count: got %0d acks want 40", acks); end
    checks++;
    if (bad_gap !== 0) begin errors++; $display("FAIL b2b_spacing: %0d bad gaps want 0", bad_gap); end
    checks++;
    if (bad_dat !== 0) begin errors++; $display("FAIL b2b_data: %0d bad words want 0", bad_dat); end
    @(posedge clk_i); #1;
    checks++;
    if (wb_ack_o !== 1'b0) begin errors++; $display("FAIL b2b_tail: ack=%b want 0", wb_ack_o); end
  endtask

  initial begin
    rst_i = 1'b1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_sel_i = 4'h0; wb_adr_i = 32'h0; wb_dat_i = 32'h0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    test_reset();
    test_ram_rw();
    test_byte_lanes();
    test_regs();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
